mt_csl_wrseq: RTL and testbench
===============================

Name: mt_csl_wrseq

Overview:
- Console-side sequencer for the magtape write-data path.
- Merges paired 32-bit console register writes (lo half 0x60, hi half 0x64, byte-strobed) into 36-bit tape words and queues them in a small FIFO.
- Delivers queued words to the MT controller over a valid/ready handshake.
- Also owns the drive configuration outputs (DPR/MOL/WRL) and a tear-free 64-bit readback of the MT data interface register.

Parameters:
- FIFO_DEPTH, 4, write-word FIFO entries; power of two, 2..16.
- CFG_RESET, 24'h000000, reset value of {WRL[7:0], MOL[7:0], DPR[7:0]}.

Ports:
- axiClk  in  1  clock.
- axiResetN  in  1  asynchronous active-low reset.
- wrLo  in  1  write strobe, lo half (bits [32:63]).
- wrHi  in  1  write strobe, hi half (bits [0:31]).
- wrCfg  in  1  write strobe, config register.
- wstrb  in  4  byte-lane enables.
- wdata  in  32  write data.
- rdLo  in  1  read strobe, lo half of readback.
- rdHi  in  1  read strobe, hi half of readback.
- rdData  out  32  readback data.
- clrErr  in  1  clear sticky overflow.
- mtDPR  out  8  drive present.
- mtMOL  out  8  media on-line.
- mtWRL  out  8  write lock.
- mtWDAT  out  36  FIFO head word, bit 0 = MSB.
- mtWVLD  out  1  head word valid.
- mtWRDY  in  1  MT accepts head word.
- mtDIRO  in  64  MT data interface register.
- fifoCnt  out  5  occupancy, 0..FIFO_DEPTH.
- ovfl  out  1  sticky overflow.
- mtDEBUG  out  64  debug counters.

Behaviour:
- Reset values (asynchronous on axiResetN low):
  - mtDPR/mtMOL/mtWRL = CFG_RESET fields.
  - mtWVLD=0, mtWDAT=0, fifoCnt=0, ovfl=0, rdData=0, mtDEBUG=0.
  - State = IDLE; staging registers cleared.
  - Reset mid-pair discards the partial word.
  - Reset mid-handshake drops the FIFO contents.
- Staging: 32-bit loReg and hiReg.
  - Each write merges wdata into the addressed half, per byte lane, where wstrb is 1.
  - Lanes with wstrb=0 keep their previous value.
- Pairing FSM, states IDLE, HAVE_LO, HAVE_HI:
  - IDLE: wrLo -> HAVE_LO; wrHi -> HAVE_HI; wrLo&wrHi in the same cycle -> complete.
  - HAVE_LO: wrLo -> stay (re-merge); wrHi -> complete.
  - HAVE_HI: wrHi -> stay; wrLo -> complete.
  - Complete: push word {hiReg'[3:0], loReg'[31:0]}, where ' denotes post-merge values; FSM -> IDLE the next cycle.
  - hiReg[31:4] is ignored for the word.
  - Pushed word appears at mtWDAT no earlier than the cycle after completion.
- FIFO:
  - Pop when mtWVLD&mtWRDY.
  - mtWVLD = (fifoCnt!=0), registered; mtWDAT is stable while mtWVLD=1 and mtWRDY=0.
  - Push while full with no pop: word dropped, ovfl set, FSM still returns to IDLE.
  - Push and pop in the same cycle while full: both take effect, count unchanged, no overflow.
  - Same cycle while empty: the word is written and becomes head next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- ovfl:
  - Cleared by clrErr.
  - If clrErr and a new overflow occur in the same cycle, ovfl=1 (set wins).
- Config:
  - wrCfg writes wdata[7:0]->DPR, [15:8]->MOL, [23:16]->WRL, honouring wstrb lanes 0..2.
  - Outputs update the next cycle.
- Readback:
  - rdLo snapshots mtDIRO[63:0] into a shadow register and returns mtDIRO[31:0] on rdData the next cycle.
  - rdHi returns shadow[63:32] without resampling, so the halves are coherent.
  - rdLo&rdHi in the same cycle: lo takes priority.
  - rdData holds its value otherwise.
- wrLo/wrHi/wrCfg/rdLo/rdHi are single-cycle pulses.

Optional Feature:
- MTCSL_WRSEQ_DEBUG_EN defined:
  - mtDEBUG = {16'b words pushed, 16'b words popped, 16'b words dropped, 8'b fifoCnt, 5'b0, 3'b state}.
  - Counters are saturating and cleared by reset only.
- Not defined: mtDEBUG tied to 0; counters absent.

Decomposition:
- Shared package mtcsl_pkg holds:
  - typedef enum of FSM states {IDLE, HAVE_LO, HAVE_HI}.
  - Constants for register offsets 0x60/0x64/config and the 36-bit word width.
  - Config field bit positions.
- One sub-module: mt_csl_wfifo, a parameterised synchronous FIFO (push/pop/full/empty/count) with async active-low reset.

Test Plan:
- Pairing: wrLo wdata=0x89ABCDEF, then wrHi wdata=0x00000005 (wstrb=F) -> mtWVLD=1, mtWDAT=36'h5_89ABCDEF.
- Reverse order with byte merge:
  - wrHi 0x3 (wstrb=F), then wrLo 0x11223344 (wstrb=F), then wrLo 0xFFFFFFFF with wstrb=4'b0001 while in HAVE_LO -> no push.
  - Then wrHi 0x3 -> head 36'h3_112233FF.
- Overflow: mtWRDY=0, push 5 words with FIFO_DEPTH=4 -> fifoCnt=4, ovfl=1, head = first word.
  - clrErr -> ovfl=0.
  - Drain -> four words popped in order.
- Full push+pop: FIFO full, assert mtWRDY on the same cycle as the completing write -> fifoCnt stays 4, ovfl=0.
- Readback coherence: mtDIRO=64'h0123456789ABCDEF, rdLo -> rdData=0x89ABCDEF.
  - Change mtDIRO to 0, then rdHi -> rdData=0x01234567.
- Reset: drop axiResetN while in HAVE_LO with 2 words queued -> immediately mtWVLD=0, fifoCnt=0, config=CFG_RESET.
  - After release, a lone wrHi does not push.

Source files
------------

// File: rtl/mt_csl_wrseq_pkg.sv
// mtcsl_pkg: shared types and constants for the magtape console write sequencer.
// Contents: pairing FSM state enum, console register offsets, tape word width,
// config field bit positions, byte-lane merge helper.
package mtcsl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HAVE_LO = 2'd1,
    HAVE_HI = 2'd2
  } seqState_t;

  localparam logic [7:0] OFS_WR_LO = 8'h60;
  localparam logic [7:0] OFS_WR_HI = 8'h64;
  localparam logic [7:0] OFS_CFG   = 8'h68;

  localparam int WORD_W = 36;

  localparam int CFG_DPR_LSB = 0;
  localparam int CFG_MOL_LSB = 8;
  localparam int CFG_WRL_LSB = 16;

  // Lanes with strb=0 keep their old byte.
  function automatic logic [31:0] mergeLanes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = oldVal;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = newVal[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mt_csl_wrseq_if.sv
// mt_csl_wrseq_if: write-word handshake between the console sequencer and
// the MT controller.
//   mtWDAT  36-bit head word; tape bit 0 (the MSB) is mtWDAT[35]
//   mtWVLD  head word valid
//   mtWRDY  MT accepts the head word this cycle
// master = sequencer side, slave = MT controller side.
interface mt_csl_wrseq_if;
  import mtcsl_pkg::*;

  logic [WORD_W-1:0] mtWDAT;
  logic              mtWVLD;
  logic              mtWRDY;

  modport master (output mtWDAT, output mtWVLD, input mtWRDY);
  modport slave  (input mtWDAT, input mtWVLD, output mtWRDY);
endinterface

// File: rtl/mt_csl_wfifo.sv
// mt_csl_wfifo: synchronous FIFO for assembled tape words.
// Ports:
//   clk, rstN     clock, asynchronous active-low reset
//   push, din     write request and data (ignored when full with no pop)
//   pop           read request (ignored when empty)
//   head          current head word, 0 while empty
//   full, empty   status
//   count         occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module mt_csl_wfifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 36,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic             doPop, doPush;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign doPop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign doPush = push & (~full | doPop);
  assign head   = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/mt_csl_wrseq.sv
// mt_csl_wrseq: console-side magtape write sequencer.
// Pairs lo/hi 32-bit console writes into 36-bit tape words, queues them and
// hands them to the MT controller; owns DPR/MOL/WRL config and a coherent
// two-read snapshot of the 64-bit MT data interface register.
// Ports:
//   axiClk, axiResetN         clock, asynchronous active-low reset
//   wrLo/wrHi/wrCfg           single-cycle write strobes (lo half, hi half, config)
//   wstrb, wdata              byte-lane enables and write data
//   rdLo/rdHi, rdData         readback strobes and data (lo snapshots, hi replays)
//   clrErr, ovfl              clear / sticky FIFO overflow
//   mtDPR/mtMOL/mtWRL         drive configuration outputs
//   mtWr                      write-word handshake (mt_csl_wrseq_if.master)
//   mtDIRO                    MT data interface register
//   fifoCnt                   FIFO occupancy
//   mtDEBUG                   debug counters, 0 unless MTCSL_WRSEQ_DEBUG_EN
//
// state   | meaning
// IDLE    | no half staged
// HAVE_LO | lo half written, waiting for hi
// HAVE_HI | hi half written, waiting for lo
module mt_csl_wrseq
  import mtcsl_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [23:0] CFG_RESET  = 24'h000000
) (
  input  logic        axiClk,
  input  logic        axiResetN,
  input  logic        wrLo,
  input  logic        wrHi,
  input  logic        wrCfg,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic        rdLo,
  input  logic        rdHi,
  output logic [31:0] rdData,
  input  logic        clrErr,
  output logic [7:0]  mtDPR,
  output logic [7:0]  mtMOL,
  output logic [7:0]  mtWRL,
  mt_csl_wrseq_if.master mtWr,
  input  logic [63:0] mtDIRO,
  output logic [4:0]  fifoCnt,
  output logic        ovfl,
  output logic [63:0] mtDEBUG
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  seqState_t         state, stateNxt;
  logic [31:0]       loReg, hiReg, loNxt, hiNxt;
  logic              complete;
  logic [WORD_W-1:0] pushWord;
  logic              popNow, dropNow;
  logic              fifoFull, fifoEmpty;
  logic [CNT_W-1:0]  cnt;
  logic [23:0]       cfgReg;
  logic [31:0]       shadowHi;

  assign loNxt    = wrLo ? mergeLanes(loReg, wdata, wstrb) : loReg;
  assign hiNxt    = wrHi ? mergeLanes(hiReg, wdata, wstrb) : hiReg;
  // Only hi[3:0] is part of the tape word; hi[31:4] is staged but ignored.
  assign pushWord = {hiNxt[3:0], loNxt};

  always_comb begin
    stateNxt = state;
    complete = 1'b0;
    case (state)
      IDLE: begin
        if (wrLo && wrHi) complete = 1'b1;
        else if (wrLo)    stateNxt = HAVE_LO;
        else if (wrHi)    stateNxt = HAVE_HI;
      end
      HAVE_LO: if (wrHi) complete = 1'b1;
      HAVE_HI: if (wrLo) complete = 1'b1;
      default: stateNxt = IDLE;
    endcase
    if (complete) stateNxt = IDLE;
  end

  always_ff @(posedge axiClk or negedge axiResetN) begin
    if (!axiResetN) begin
      state <= IDLE;
      loReg <= '0;
      hiReg <= '0;
    end else begin
      state <= stateNxt;
      loReg <= loNxt;
      hiReg <= hiNxt;
    end
  end

  assign popNow  = mtWr.mtWVLD & mtWr.mtWRDY;
  assign dropNow = complete & fifoFull & ~popNow;

  mt_csl_wfifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) uFifo (
    .clk   (axiClk),
    .rstN  (axiResetN),
    .push  (complete),
    .din   (pushWord),
    .pop   (popNow),
    .head  (mtWr.mtWDAT),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (cnt)
  );

  assign mtWr.mtWVLD = ~fifoEmpty;
  assign fifoCnt     = 5'(cnt);

  always_ff @(posedge axiClk or negedge axiResetN) begin
    if (!axiResetN)   ovfl <= 1'b0;
    else if (dropNow) ovfl <= 1'b1;
    else if (clrErr)  ovfl <= 1'b0;
  end

  always_ff @(posedge axiClk or negedge axiResetN) begin
    if (!axiResetN) begin
      cfgReg <= CFG_RESET;
    end else if (wrCfg) begin
      for (int i = 0; i < 3; i++) begin
        if (wstrb[i]) cfgReg[i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign mtDPR = cfgReg[CFG_DPR_LSB +: 8];
  assign mtMOL = cfgReg[CFG_MOL_LSB +: 8];
  assign mtWRL = cfgReg[CFG_WRL_LSB +: 8];

  // The lo read returns live data directly, so only the upper half of the
  // snapshot needs to be held for the following hi read.
  always_ff @(posedge axiClk or negedge axiResetN) begin
    if (!axiResetN) begin
      shadowHi <= '0;
      rdData   <= '0;
    end else if (rdLo) begin
      shadowHi <= mtDIRO[63:32];
      rdData   <= mtDIRO[31:0];
    end else if (rdHi) begin
      rdData   <= shadowHi;
    end
  end

`ifdef MTCSL_WRSEQ_DEBUG_EN
  logic [15:0] nPush, nPop, nDrop;
  logic        pushOk;

  assign pushOk = complete & ~dropNow;

  always_ff @(posedge axiClk or negedge axiResetN) begin
    if (!axiResetN) begin
      nPush <= '0;
      nPop  <= '0;
      nDrop <= '0;
    end else begin
      if (pushOk  && nPush != 16'hFFFF) nPush <= nPush + 1'b1;
      if (popNow  && nPop  != 16'hFFFF) nPop  <= nPop + 1'b1;
      if (dropNow && nDrop != 16'hFFFF) nDrop <= nDrop + 1'b1;
    end
  end

  assign mtDEBUG = {nPush, nPop, nDrop, 3'b000, fifoCnt, 5'b00000, 1'b0, state};
`else
  assign mtDEBUG = '0;
`endif

endmodule

// File: tb/tb_mt_csl_wrseq.sv
module tb_mt_csl_wrseq;
  import mtcsl_pkg::*;

  logic        axiClk = 1'b0;
  logic        axiResetN = 1'b0;
  logic        wrLo = 1'b0, wrHi = 1'b0, wrCfg = 1'b0;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] wdata = '0;
  logic        rdLo = 1'b0, rdHi = 1'b0;
  logic [31:0] rdData;
  logic        clrErr = 1'b0;
  logic [7:0]  mtDPR, mtMOL, mtWRL;
  logic [63:0] mtDIRO = '0;
  logic [4:0]  fifoCnt;
  logic        ovfl;
  logic [63:0] mtDEBUG;

  int nCmp = 0;
  int nBad = 0;

  mt_csl_wrseq_if mtIf ();

  mt_csl_wrseq #(.FIFO_DEPTH(4), .CFG_RESET(24'h000000)) dut (
    .axiClk    (axiClk),
    .axiResetN (axiResetN),
    .wrLo      (wrLo),
    .wrHi      (wrHi),
    .wrCfg     (wrCfg),
    .wstrb     (wstrb),
    .wdata     (wdata),
    .rdLo      (rdLo),
    .rdHi      (rdHi),
    .rdData    (rdData),
    .clrErr    (clrErr),
    .mtDPR     (mtDPR),
    .mtMOL     (mtMOL),
    .mtWRL     (mtWRL),
    .mtWr      (mtIf.master),
    .mtDIRO    (mtDIRO),
    .fifoCnt   (fifoCnt),
    .ovfl      (ovfl),
    .mtDEBUG   (mtDEBUG)
  );

  always #5 axiClk = ~axiClk;

  // One-cycle bus pulse; returns at the negedge after the capturing posedge.
  task automatic busWr(input logic lo, input logic hi, input logic cfg,
                       input logic [3:0] s, input logic [31:0] d,
                       input logic rdy, input logic clr);
    @(negedge axiClk);
    wrLo = lo; wrHi = hi; wrCfg = cfg; wstrb = s; wdata = d;
    mtIf.mtWRDY = rdy; clrErr = clr;
    @(negedge axiClk);
    wrLo = 1'b0; wrHi = 1'b0; wrCfg = 1'b0; mtIf.mtWRDY = 1'b0; clrErr = 1'b0;
  endtask

  task automatic wrL(input logic [31:0] d);
    busWr(1'b1, 1'b0, 1'b0, 4'hF, d, 1'b0, 1'b0);
  endtask

  task automatic wrH(input logic [31:0] d);
    busWr(1'b0, 1'b1, 1'b0, 4'hF, d, 1'b0, 1'b0);
  endtask

  task automatic popOne();
    busWr(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic rdPulse(input logic lo, input logic hi);
    @(negedge axiClk);
    rdLo = lo; rdHi = hi;
    @(negedge axiClk);
    rdLo = 1'b0; rdHi = 1'b0;
  endtask

  task automatic test_reset();
    axiResetN = 1'b0;
    mtIf.mtWRDY = 1'b0;
    repeat (3) @(negedge axiClk);
    nCmp++; if (mtIf.mtWVLD !== 1'b0) begin nBad++; $display("FAIL rst_wvld: got %b want 0", mtIf.mtWVLD); end
    nCmp++; if (mtIf.mtWDAT !== 36'h0) begin nBad++; $display("FAIL rst_wdat: got %h want 0", mtIf.mtWDAT); end
    nCmp++; if (fifoCnt !== 5'd0) begin nBad++; $display("FAIL rst_cnt: got %0d want 0", fifoCnt); end
    nCmp++; if (ovfl !== 1'b0) begin nBad++; $display("FAIL rst_ovfl: got %b want 0", ovfl); end
    nCmp++; if (rdData !== 32'h0) begin nBad++; $display("FAIL rst_rddata: got %h want 0", rdData); end
    nCmp++; if ({mtWRL, mtMOL, mtDPR} !== 24'h000000) begin nBad++; $display("FAIL rst_cfg: got %h want 000000", {mtWRL, mtMOL, mtDPR}); end
    nCmp++; if (mtDEBUG !== 64'h0) begin nBad++; $display("FAIL rst_debug: got %h want 0", mtDEBUG); end
    axiResetN = 1'b1;
    @(negedge axiClk);
  endtask

  task automatic test_pairing();
    wrL(32'h89ABCDEF);
    nCmp++; if (fifoCnt !== 5'd0) begin nBad++; $display("FAIL pair_lo_only: cnt got %0d want 0", fifoCnt); end
    wrH(32'h00000005);
    nCmp++; if (mtIf.mtWVLD !== 1'b1) begin nBad++; $display("FAIL pair_wvld: got %b want 1", mtIf.mtWVLD); end
    nCmp++; if (mtIf.mtWDAT !== 36'h5_89ABCDEF) begin nBad++; $display("FAIL pair_head: got %h want 589abcdef", mtIf.mtWDAT); end
    popOne();
    nCmp++; if (mtIf.mtWVLD !== 1'b0 || fifoCnt !== 5'd0) begin nBad++; $display("FAIL pair_drain: wvld %b cnt %0d want 0 0", mtIf.mtWVLD, fifoCnt); end
  endtask

  task automatic test_reverse_merge();
    wrH(32'h00000003);
    nCmp++; if (fifoCnt !== 5'd0) begin nBad++; $display("FAIL rev_hi_only: cnt got %0d want 0", fifoCnt); end
    wrL(32'h11223344);
    nCmp++; if (mtIf.mtWDAT !== 36'h3_11223344) begin nBad++; $display("FAIL rev_head1: got %h want 311223344", mtIf.mtWDAT); end
    popOne();
    busWr(1'b1, 1'b0, 1'b0, 4'b0001, 32'hFFFFFFFF, 1'b0, 1'b0);
    nCmp++; if (fifoCnt !== 5'd0) begin nBad++; $display("FAIL rev_lo_merge_nopush: cnt got %0d want 0", fifoCnt); end
    wrH(32'h00000003);
    nCmp++; if (mtIf.mtWDAT !== 36'h3_112233FF) begin nBad++; $display("FAIL rev_head2: got %h want 3112233ff", mtIf.mtWDAT); end
    popOne();
  endtask

  task automatic test_overflow();
    logic [35:0] exp [5];
    for (int i = 0; i < 5; i++) exp[i] = {4'(i + 1), 32'hA0000000 + 32'(i)};
    for (int i = 0; i < 4; i++) begin
      wrL(exp[i][31:0]);
      wrH({28'h0, exp[i][35:32]});
    end
    nCmp++; if (fifoCnt !== 5'd4 || ovfl !== 1'b0) begin nBad++; $display("FAIL ovf_fill: cnt %0d ovfl %b want 4 0", fifoCnt, ovfl); end
    wrL(exp[4][31:0]);
    wrH({28'h0, exp[4][35:32]});
    nCmp++; if (fifoCnt !== 5'd4) begin nBad++; $display("FAIL ovf_cnt: got %0d want 4", fifoCnt); end
    nCmp++; if (ovfl !== 1'b1) begin nBad++; $display("FAIL ovf_flag: got %b want 1", ovfl); end
    nCmp++; if (mtIf.mtWDAT !== exp[0]) begin nBad++; $display("FAIL ovf_head: got %h want %h", mtIf.mtWDAT, exp[0]); end
    busWr(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
    nCmp++; if (ovfl !== 1'b0) begin nBad++; $display("FAIL ovf_clr: got %b want 0", ovfl); end
    wrL(32'hDEAD0000);
    busWr(1'b0, 1'b1, 1'b0, 4'hF, 32'h0000000F, 1'b0, 1'b1);
    nCmp++; if (ovfl !== 1'b1) begin nBad++; $display("FAIL ovf_set_wins: got %b want 1", ovfl); end
    busWr(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      nCmp++; if (mtIf.mtWDAT !== exp[i]) begin nBad++; $display("FAIL ovf_drain_%0d: got %h want %h", i, mtIf.mtWDAT, exp[i]); end
      popOne();
    end
    nCmp++; if (fifoCnt !== 5'd0 || mtIf.mtWVLD !== 1'b0) begin nBad++; $display("FAIL ovf_empty: cnt %0d wvld %b want 0 0", fifoCnt, mtIf.mtWVLD); end
  endtask

  task automatic test_full_push_pop();
    logic [35:0] exp [5];
    for (int i = 0; i < 5; i++) exp[i] = {4'(9 - i), 32'h5EED0000 + 32'(i * 17)};
    for (int i = 0; i < 4; i++) begin
      wrL(exp[i][31:0]);
      wrH({28'h0, exp[i][35:32]});
    end
    wrL(exp[4][31:0]);
    busWr(1'b0, 1'b1, 1'b0, 4'hF, {28'h0, exp[4][35:32]}, 1'b1, 1'b0);
    nCmp++; if (fifoCnt !== 5'd4) begin nBad++; $display("FAIL fpp_cnt: got %0d want 4", fifoCnt); end
    nCmp++; if (ovfl !== 1'b0) begin nBad++; $display("FAIL fpp_ovfl: got %b want 0", ovfl); end
    for (int i = 1; i < 5; i++) begin
      nCmp++; if (mtIf.mtWDAT !== exp[i]) begin nBad++; $display("FAIL fpp_drain_%0d: got %h want %h", i, mtIf.mtWDAT, exp[i]); end
      popOne();
    end
    nCmp++; if (fifoCnt !== 5'd0) begin nBad++; $display("FAIL fpp_empty: cnt got %0d want 0", fifoCnt); end
  endtask

  task automatic test_readback();
    mtDIRO = 64'h0123456789ABCDEF;
    rdPulse(1'b1, 1'b0);
    nCmp++; if (rdData !== 32'h89ABCDEF) begin nBad++; $display("FAIL rb_lo: got %h want 89abcdef", rdData); end
    mtDIRO = 64'h0;
    rdPulse(1'b0, 1'b1);
    nCmp++; if (rdData !== 32'h01234567) begin nBad++; $display("FAIL rb_hi: got %h want 01234567", rdData); end
    repeat (2) @(negedge axiClk);
    nCmp++; if (rdData !== 32'h01234567) begin nBad++; $display("FAIL rb_hold: got %h want 01234567", rdData); end
    mtDIRO = 64'hCAFEBABE_DEADBEEF;
    rdPulse(1'b1, 1'b1);
    nCmp++; if (rdData !== 32'hDEADBEEF) begin nBad++; $display("FAIL rb_both: got %h want deadbeef", rdData); end
    rdPulse(1'b0, 1'b1);
    nCmp++; if (rdData !== 32'hCAFEBABE) begin nBad++; $display("FAIL rb_hi2: got %h want cafebabe", rdData); end
  endtask

  task automatic test_config();
    busWr(1'b0, 1'b0, 1'b1, 4'b0111, 32'h11A55A3C, 1'b0, 1'b0);
    nCmp++; if ({mtWRL, mtMOL, mtDPR} !== 24'hA55A3C) begin nBad++; $display("FAIL cfg_all: got %h want a55a3c", {mtWRL, mtMOL, mtDPR}); end
    busWr(1'b0, 1'b0, 1'b1, 4'b0010, 32'hFFFFFFFF, 1'b0, 1'b0);
    nCmp++; if ({mtWRL, mtMOL, mtDPR} !== 24'hA5FF3C) begin nBad++; $display("FAIL cfg_lane1: got %h want a5ff3c", {mtWRL, mtMOL, mtDPR}); end
  endtask

  task automatic test_reset_midflight();
    wrL(32'h00000001); wrH(32'h00000001);
    wrL(32'h00000002); wrH(32'h00000002);
    wrL(32'h00000003);
    nCmp++; if (fifoCnt !== 5'd2) begin nBad++; $display("FAIL rmf_pre_cnt: got %0d want 2", fifoCnt); end
    @(negedge axiClk);
    axiResetN = 1'b0;
    #1;
    nCmp++; if (mtIf.mtWVLD !== 1'b0 || fifoCnt !== 5'd0) begin nBad++; $display("FAIL rmf_async: wvld %b cnt %0d want 0 0", mtIf.mtWVLD, fifoCnt); end
    nCmp++; if ({mtWRL, mtMOL, mtDPR} !== 24'h000000) begin nBad++; $display("FAIL rmf_cfg: got %h want 000000", {mtWRL, mtMOL, mtDPR}); end
    @(negedge axiClk);
    axiResetN = 1'b1;
    wrH(32'h00000007);
    nCmp++; if (fifoCnt !== 5'd0) begin nBad++; $display("FAIL rmf_lone_hi: cnt got %0d want 0", fifoCnt); end
    wrL(32'h12345678);
    nCmp++; if (fifoCnt !== 5'd1 || mtIf.mtWDAT !== 36'h7_12345678) begin nBad++; $display("FAIL rmf_pair: cnt %0d head %h want 1 712345678", fifoCnt, mtIf.mtWDAT); end
    popOne();
  endtask

  initial begin
    mtIf.mtWRDY = 1'b0;
    test_reset();
    test_pairing();
    test_reverse_merge();
    test_overflow();
    test_full_push_pop();
    test_readback();
    test_config();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
